// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, states,
// ALU/mux select codes and the control word passed from the output decoder.
package multicycle_main_controller_pkg;

  localparam int STATE_ENC_W = 4;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_main_controller_outdec.sv
// Moore output decoder: maps the current controller state to the datapath
// control word. Only FETCH depends on mem_ready (IR/PC load on completion).
module main_ctrl_outdec
  import multicycle_main_controller_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  // state -> control word; unused codes give an all-zero word
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMMSH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        o_ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multicycle MIPS main controller: state register, next-state logic,
// reset gating of write enables and the illegal-opcode pulse.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_J    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  ctrl_t  w_ctrl;

  main_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // next-state selection; op is only looked at in DECODE and MEMADR
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(op))                 w_next = S_MEMADR;
        else if (op == OP_RTYPE)           w_next = S_EXECUTE;
        else if (op == OP_BEQ)             w_next = S_BRANCH;
        else if (EN_ADDI && op == OP_ADDI) w_next = S_ADDIEX;
        else if (EN_J && op == OP_J)       w_next = S_JUMP;
        else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEX:   w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // state register, forced to FETCH while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // write strobes are masked by rst_n so nothing commits during reset
  assign PCEn       = rst_n & (w_ctrl.pc_write | (w_ctrl.branch & zero));
  assign IRWrite    = rst_n & w_ctrl.ir_write;
  assign MemWrite   = rst_n & w_ctrl.mem_write;
  assign RegWrite   = rst_n & w_ctrl.reg_write;
  assign illegal_op = rst_n & w_illegal;

  assign IorD      = w_ctrl.iord;
  assign RegDst    = w_ctrl.reg_dst;
  assign MemtoReg  = w_ctrl.mem_to_reg;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ALUOp     = w_ctrl.alu_op;
  assign PCSrc     = w_ctrl.pc_src;
  assign state_dbg = STATE_W'(r_state);

endmodule
